cmp_result_rx: RTL and testbench
================================

Name: cmp_result_rx

Overview:
- Receiving end of the comparator result interface. Accepts {OUT1, OUT2} result words over a valid/ready stream.
- Classifies each word and unpacks it into the max operand and the operand pair.
- Buffers decoded entries in a small FIFO for a downstream consumer.
- Keeps saturating statistics counters for monitoring and debug.

Parameters:
- N, 5, operand width; result words are 2N bits wide.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CW, 16, statistics counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  an input result word is present.
- in_ready  out  1  block can accept a word.
- in_out1  in  2N  OUT1 field of the result word.
- in_out2  in  2N  OUT2 field of the result word.
- out_valid  out  1  FIFO head entry is valid.
- out_ready  in  1  consumer takes the head entry.
- max_val  out  N  decoded max operand (or the equal value).
- pair_hi  out  N  decoded upper pair operand.
- pair_lo  out  N  decoded lower pair operand.
- kind  out  2  0 = TIE_ZERO, 1 = ALL_EQUAL, 2 = MAX, 3 = MALFORMED.
- level  out  log2(DEPTH)+1  FIFO occupancy.
- clr_stats  in  1  synchronous clear of the counters.
- cnt_words  out  CW  accepted words, saturating.
- cnt_bad  out  CW  MALFORMED words, saturating.

Behaviour:
- Reset (async, rst_n = 0): FIFO empty, level = 0, out_valid = 0, in_ready = 1, counters = 0, max_val/pair_hi/pair_lo/kind = 0. Reset asserted mid-transfer discards all buffered entries.
- Handshake:
  - Input accept = in_valid & in_ready.
  - Output pop = out_valid & out_ready.
  - in_ready = (level != DEPTH); it depends only on registered state, with no combinational path from out_ready.
  - out_valid = (level != 0).
  - Data outputs show the FIFO head and hold stable while out_valid & !out_ready.
- Classification runs combinationally on the accepted word. First matching rule wins:
  1. TIE_ZERO: in_out1 == 0 and in_out2 == 0. Fields all 0.
  2. ALL_EQUAL: in_out1[1:0] == 0, in_out1[2N-1:N+2] == 0, and in_out2 == (in_out1 >> 4). Fields: max_val = pair_hi = pair_lo = in_out1[N+1:2].
  3. MALFORMED: in_out1[2N-1:N] != N copies of in_out1[N-1]. Fields: max_val = in_out1[N-1:0], pair_hi = in_out2[2N-1:N], pair_lo = in_out2[N-1:0].
  4. MAX: all other words. Same field mapping as MALFORMED.
- Collision priority: a MAX word that satisfies rule 2 is reported as ALL_EQUAL. This is by design; the verifier checks for it.
- Latency: a word accepted in cycle t is visible at the head no earlier than cycle t+1. There is no combinational input-to-output path. When the FIFO is empty, out_valid rises in t+1.
- FIFO behaviour:
  - Circular buffer with read/write pointers wrapping modulo DEPTH.
  - Push and pop in the same cycle: both happen and level is unchanged, including at level == DEPTH-1 and at level == 1.
  - When full, in_ready = 0, so there is no push. A pop that cycle frees one slot, and in_ready rises the next cycle.
  - Pop when empty cannot occur because out_valid = 0.
- Counters:
  - cnt_words increments on every accept.
  - cnt_bad increments on every MALFORMED accept.
  - Both saturate at 2^CW-1 and never wrap.
  - clr_stats zeroes both next edge. clr_stats has priority over an increment in the same cycle; that word is not counted.
- Widths: all slicing is exact; no sign handling beyond the MALFORMED extension check.

Test Plan:
- Reset then idle: after rst_n released -> in_ready = 1, out_valid = 0, level = 0, counters = 0. Assert rst_n low mid-burst with level = 3 -> level = 0 immediately, out_valid = 0.
- N=5, MAX word: in_out1 = 0x3F4, in_out2 = 0x061 -> one cycle later out_valid = 1, kind = 2, max_val = 20, pair_hi = 3, pair_lo = 1; cnt_words = 1.
- Equal and zero words:
  - in_out1 = 0x018, in_out2 = 0x001 -> kind = 1, all fields = 6.
  - in_out1 = 0, in_out2 = 0 -> kind = 0, fields = 0.
- Malformed: in_out1 = 0x0E5, in_out2 = 0x123 -> kind = 3, max_val = 5, pair_hi = 9, pair_lo = 3; cnt_bad = 1.
- Backpressure:
  - Hold out_ready = 0 and push 5 words with DEPTH = 4 -> in_ready falls after the 4th accept and the 5th waits; head data stays stable.
  - Then pulse out_ready for one cycle -> in_ready returns the next cycle and the 5th word is accepted.
  - Streaming with in_valid = out_ready = 1 -> throughput of 1 word/cycle with level steady.
- Counters: preload with CW = 4 and push 17 words -> cnt_words saturates at 15. clr_stats asserted together with an accept -> cnt_words = 0 next cycle.

Source files
------------

// File: rtl/cmp_result_rx_if.sv
// Stream interface for cmp_result_rx: an inbound {OUT1, OUT2} result-word
// stream and an outbound decoded-entry stream, each with valid/ready.
interface cmp_result_rx_if #(
    parameter int N = 5
);
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] in_out1;
    logic [2*N-1:0] in_out2;

    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   max_val;
    logic [N-1:0]   pair_hi;
    logic [N-1:0]   pair_lo;
    logic [1:0]     kind;

    modport slave (
        input  in_valid, in_out1, in_out2, out_ready,
        output in_ready, out_valid, max_val, pair_hi, pair_lo, kind
    );

    modport master (
        output in_valid, in_out1, in_out2, out_ready,
        input  in_ready, out_valid, max_val, pair_hi, pair_lo, kind
    );
endinterface

// File: rtl/cmp_result_rx.sv
// Comparator result receiver: classifies {OUT1, OUT2} words, buffers decoded
// entries in a circular FIFO and keeps saturating accept/malformed counters.
module cmp_result_rx #(
    parameter int N     = 5,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cmp_result_rx_if.slave           bus,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     clr_stats,
    output logic [CW-1:0]            cnt_words,
    output logic [CW-1:0]            cnt_bad
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 3 * N + 2;
    localparam int EQ_SHIFT = 4;
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        KIND_TIE = 2'd0,
        KIND_EQ  = 2'd1,
        KIND_MAX = 2'd2,
        KIND_BAD = 2'd3
    } kind_e;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     level_q, level_d;
    logic [CW-1:0]   cnt_words_q, cnt_words_d;
    logic [CW-1:0]   cnt_bad_q, cnt_bad_d;

    kind_e           cls_kind_s;
    logic [N-1:0]    cls_max_s, cls_hi_s, cls_lo_s;
    logic            push_s, pop_s;
    logic [EW-1:0]   head_s;

    assign bus.in_ready  = (level_q != LVL_FULL);
    assign bus.out_valid = (level_q != '0);
    assign push_s        = bus.in_valid & bus.in_ready;
    assign pop_s         = bus.out_valid & bus.out_ready;

    // Classify the incoming word; first matching rule wins.
    always_comb begin
        cls_kind_s = KIND_MAX;
        cls_max_s  = bus.in_out1[N-1:0];
        cls_hi_s   = bus.in_out2[2*N-1:N];
        cls_lo_s   = bus.in_out2[N-1:0];
        if ((bus.in_out1 == '0) && (bus.in_out2 == '0)) begin
            cls_kind_s = KIND_TIE;
            cls_max_s  = '0;
            cls_hi_s   = '0;
            cls_lo_s   = '0;
        end else if ((bus.in_out1[1:0] == 2'b00) && (bus.in_out1[2*N-1:N+2] == '0) &&
                     (bus.in_out2 == (bus.in_out1 >> EQ_SHIFT))) begin
            // ALL_EQUAL deliberately shadows MAX words of the same shape
            cls_kind_s = KIND_EQ;
            cls_max_s  = bus.in_out1[N+1:2];
            cls_hi_s   = bus.in_out1[N+1:2];
            cls_lo_s   = bus.in_out1[N+1:2];
        end else if (bus.in_out1[2*N-1:N] != {N{bus.in_out1[N-1]}}) begin
            cls_kind_s = KIND_BAD;
        end else begin
            cls_kind_s = KIND_MAX;
        end
    end

    // Occupancy next state; simultaneous push and pop leave it unchanged.
    always_comb begin
        level_d = level_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + (AW + 1)'(1'b1);
            2'b01:   level_d = level_q - (AW + 1)'(1'b1);
            default: level_d = level_q;
        endcase
    end

    // Statistics next state; a clear wins over a same-cycle increment.
    always_comb begin
        cnt_words_d = cnt_words_q;
        cnt_bad_d   = cnt_bad_q;
        if (clr_stats) begin
            cnt_words_d = '0;
            cnt_bad_d   = '0;
        end else if (push_s) begin
            if (cnt_words_q != CNT_MAX) begin
                cnt_words_d = cnt_words_q + CW'(1'b1);
            end else begin
                cnt_words_d = cnt_words_q;
            end
            if ((cls_kind_s == KIND_BAD) && (cnt_bad_q != CNT_MAX)) begin
                cnt_bad_d = cnt_bad_q + CW'(1'b1);
            end else begin
                cnt_bad_d = cnt_bad_q;
            end
        end else begin
            cnt_words_d = cnt_words_q;
            cnt_bad_d   = cnt_bad_q;
        end
    end

    // FIFO storage, pointers, occupancy and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_words_q <= '0;
            cnt_bad_q   <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= {cls_kind_s, cls_max_s, cls_hi_s, cls_lo_s};
                wr_ptr_q        <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            level_q     <= level_d;
            cnt_words_q <= cnt_words_d;
            cnt_bad_q   <= cnt_bad_d;
        end
    end

    assign head_s      = mem_q[rd_ptr_q];
    assign bus.kind    = head_s[EW-1:3*N];
    assign bus.max_val = head_s[3*N-1:2*N];
    assign bus.pair_hi = head_s[2*N-1:N];
    assign bus.pair_lo = head_s[N-1:0];
    assign level       = level_q;
    assign cnt_words   = cnt_words_q;
    assign cnt_bad     = cnt_bad_q;
endmodule

// File: tb/tb_cmp_result_rx.sv
// Scoreboard bench for cmp_result_rx (N=5, DEPTH=4, CW=4): expected entries
// are queued on accept and compared against the FIFO head on every pop.
module tb_cmp_result_rx;
    localparam int N     = 5;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_stats = 1'b0;
    logic [2:0]    level;
    logic [CW-1:0] cnt_words, cnt_bad;

    cmp_result_rx_if #(.N(N)) bus_if ();

    cmp_result_rx #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .level     (level),
        .clr_stats (clr_stats),
        .cnt_words (cnt_words),
        .cnt_bad   (cnt_bad)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [16:0] sb [$];
    int          exp_words = 0;
    int          exp_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: {kind, max, hi, lo}
    function automatic logic [16:0] ref_decode(input logic [9:0] a, input logic [9:0] b);
        if (a == 10'd0 && b == 10'd0) return 17'd0;
        if (a[1:0] == 2'b00 && a[9:7] == 3'b000 && b == {4'b0000, a[9:4]})
            return {2'd1, a[6:2], a[6:2], a[6:2]};
        if (a[9:5] != {5{a[4]}}) return {2'd3, a[4:0], b[9:5], b[4:0]};
        return {2'd2, a[4:0], b[9:5], b[4:0]};
    endfunction

    // Monitor: checks status vs model, pops on consume, pushes on accept
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_n) begin
            sb.delete();
            exp_words = 0;
            exp_bad   = 0;
        end else begin
            chk("level", level, sb.size());
            chk("in_ready", bus_if.in_ready, sb.size() != DEPTH);
            chk("out_valid", bus_if.out_valid, sb.size() != 0);
            chk("cnt_words", cnt_words, exp_words);
            chk("cnt_bad", cnt_bad, exp_bad);
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("head", {bus_if.kind, bus_if.max_val, bus_if.pair_hi, bus_if.pair_lo}, e);
                end
            end
            if (bus_if.in_valid && bus_if.in_ready) begin
                e = ref_decode(bus_if.in_out1, bus_if.in_out2);
                sb.push_back(e);
            end
            if (clr_stats) begin
                exp_words = 0;
                exp_bad   = 0;
            end else if (bus_if.in_valid && bus_if.in_ready) begin
                if (exp_words < CMAX) exp_words++;
                if (e[16:15] == 2'd3 && exp_bad < CMAX) exp_bad++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [9:0] o1, input logic [9:0] o2);
        int waited = 0;
        bus_if.in_out1  = o1;
        bus_if.in_out2  = o2;
        bus_if.in_valid = 1'b1;
        while (!bus_if.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("send_wait", waited < 20, 1);
        tick();
        bus_if.in_valid = 1'b0;
    endtask

    task automatic pop_one();
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
    endtask

    task automatic drain();
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 40 && level != 3'd0; i++) tick();
        chk("drain", level, 0);
        bus_if.out_ready = 1'b0;
    endtask

    function automatic logic [19:0] rand_word();
        logic [4:0] a, b, c;
        logic [9:0] o1, o2;
        a = 5'($urandom);
        b = 5'($urandom);
        c = 5'($urandom);
        case ($urandom_range(0, 3))
            0:       begin o1 = 10'd0; o2 = 10'd0; end
            1:       begin o1 = {3'b000, a, 2'b00}; o2 = o1 >> 4; end
            2:       begin o1 = {{5{a[4]}}, a}; o2 = {b, c}; end
            default: begin o1 = 10'($urandom); o2 = 10'($urandom); end
        endcase
        return {o1, o2};
    endfunction

    initial begin
        logic [19:0] w;
        logic [9:0]  first_o1, first_o2;
        logic [16:0] first_exp;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.in_out1   = 10'd0;
        bus_if.in_out2   = 10'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        chk("rst_in_ready", bus_if.in_ready, 1);
        chk("rst_out_valid", bus_if.out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_cnt_words", cnt_words, 0);
        chk("rst_kind", bus_if.kind, 0);

        send_one(10'h3F4, 10'h061);
        chk("max_valid", bus_if.out_valid, 1);
        chk("max_kind", bus_if.kind, 2);
        chk("max_val", bus_if.max_val, 20);
        chk("max_hi", bus_if.pair_hi, 3);
        chk("max_lo", bus_if.pair_lo, 1);
        chk("max_cnt", cnt_words, 1);
        pop_one();

        send_one(10'h018, 10'h001);
        chk("eq_kind", bus_if.kind, 1);
        chk("eq_fields", {bus_if.max_val, bus_if.pair_hi, bus_if.pair_lo}, {5'd6, 5'd6, 5'd6});
        pop_one();

        send_one(10'h000, 10'h000);
        chk("zero_kind", bus_if.kind, 0);
        chk("zero_fields", {bus_if.max_val, bus_if.pair_hi, bus_if.pair_lo}, 0);
        pop_one();

        send_one(10'h0E5, 10'h123);
        chk("bad_kind", bus_if.kind, 3);
        chk("bad_fields", {bus_if.max_val, bus_if.pair_hi, bus_if.pair_lo}, {5'd5, 5'd9, 5'd3});
        chk("bad_cnt", cnt_bad, 1);
        pop_one();

        // Backpressure: four accepted, fifth stalls with head held
        first_o1  = {5'b00000, 5'd7};
        first_o2  = {5'd2, 5'd4};
        first_exp = ref_decode(first_o1, first_o2);
        send_one(first_o1, first_o2);
        for (int i = 0; i < 3; i++) begin
            w = rand_word();
            send_one(w[19:10], w[9:0]);
        end
        chk("full_in_ready", bus_if.in_ready, 0);
        chk("full_level", level, 4);
        w = rand_word();
        bus_if.in_out1  = w[19:10];
        bus_if.in_out2  = w[9:0];
        bus_if.in_valid = 1'b1;
        tick();
        tick();
        chk("stall_in_ready", bus_if.in_ready, 0);
        chk("stall_head", {bus_if.kind, bus_if.max_val, bus_if.pair_hi, bus_if.pair_lo}, first_exp);
        pop_one();
        chk("freed_in_ready", bus_if.in_ready, 1);
        chk("freed_level", level, 3);
        tick();
        bus_if.in_valid = 1'b0;
        chk("fifth_level", level, 4);
        drain();

        // Streaming at level 1
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w = rand_word();
            bus_if.in_out1 = w[19:10];
            bus_if.in_out2 = w[9:0];
            tick();
            chk("stream_level", level, 1);
        end
        bus_if.in_valid = 1'b0;
        drain();

        // Push and pop together at level DEPTH-1, then reset mid-burst
        for (int i = 0; i < 3; i++) begin
            w = rand_word();
            send_one(w[19:10], w[9:0]);
        end
        w = rand_word();
        bus_if.in_out1   = w[19:10];
        bus_if.in_out2   = w[9:0];
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        chk("pushpop3_level", level, 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_level", level, 0);
        chk("midrst_out_valid", bus_if.out_valid, 0);
        chk("midrst_in_ready", bus_if.in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Counter saturation and clear-over-increment
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            w = rand_word();
            bus_if.in_out1 = w[19:10];
            bus_if.in_out2 = w[9:0];
            tick();
        end
        chk("sat_words", cnt_words, 15);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        bus_if.in_valid = 1'b0;
        chk("clr_words", cnt_words, 0);
        chk("clr_bad", cnt_bad, 0);
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            w = rand_word();
            bus_if.in_out1   = w[19:10];
            bus_if.in_out2   = w[9:0];
            bus_if.in_valid  = 1'($urandom_range(0, 1));
            bus_if.out_ready = 1'($urandom_range(0, 1));
            clr_stats        = ($urandom_range(0, 31) == 0);
            tick();
        end
        bus_if.in_valid = 1'b0;
        clr_stats       = 1'b0;
        drain();
        tick();
        chk("sb_final", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
